// File: rtl/pwm_pkg.sv
// Shared definitions for the LED PWM chain: duty width, phase encodings and a
// counter-width helper used by the prescaler and dwell counters.
package pwm_pkg;

    localparam int DUTY_W = 8;

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_UP   = 3'd1,
        PH_TOP  = 3'd2,
        PH_DOWN = 3'd3,
        PH_BOT  = 3'd4
    } phase_e;

    // Width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler producing a one-cycle step tick every PRESCALE running cycles.
// The tick is combinational from the count so the consumer can register it.
module pwm_tick_gen
    import pwm_pkg::*;
#(
    parameter int unsigned PRESCALE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = cnt_width(PRESCALE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = run && !clear && (cnt_q == CNT_LAST);

    // clear wins over run; run low with clear low holds the count (freeze)
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Breathing-effect duty generator: triangular ramp MIN->MAX->MIN with optional
// dwell at both ends, driven by a prescaled step tick.
//
// state   | meaning
// IDLE    | disabled, duty held at DUTY_MIN
// UP      | duty rises by STEP per tick, saturating at DUTY_MAX
// TOP     | dwell at DUTY_MAX for DWELL ticks
// DOWN    | duty falls by STEP per tick, clamping at DUTY_MIN
// BOT     | dwell at DUTY_MIN for DWELL ticks, then period_done
module pwm_fade_ctrl
    import pwm_pkg::*;
#(
    parameter int unsigned       PRESCALE = 16,
    parameter int unsigned       STEP     = 8,
    parameter int unsigned       DWELL    = 2,
    parameter logic [DUTY_W-1:0] DUTY_MAX = 8'd255,
    parameter logic [DUTY_W-1:0] DUTY_MIN = 8'd0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              freeze,
    output logic [DUTY_W-1:0] duty_cycle,
    output logic              tick,
    output logic [2:0]        phase,
    output logic              period_done
);

    localparam int unsigned DWELL_W = cnt_width(DWELL + 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL);
    localparam bit SKIP_DWELL = (DWELL == 0);
    localparam logic [DUTY_W:0]   STEP_9  = (DUTY_W + 1)'(STEP);
    localparam logic signed [DUTY_W+1:0] STEP_10 = (DUTY_W + 2)'(STEP);

    phase_e              state_q, state_d;
    logic [DUTY_W-1:0]   duty_q, duty_d;
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic                tick_q, tick_d;
    logic                done_q, done_d;

    logic                step_tick;
    logic                pre_run;
    logic                pre_clear;
    logic [DUTY_W:0]     sum_up;
    logic signed [DUTY_W+1:0] diff_dn;
    logic [DWELL_W-1:0]  dwell_inc;

    assign pre_run   = enable && !freeze && (state_q != PH_IDLE);
    assign pre_clear = !enable || (state_q == PH_IDLE);

    pwm_tick_gen #(
        .PRESCALE (PRESCALE)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .run   (pre_run),
        .clear (pre_clear),
        .tick  (step_tick)
    );

    assign sum_up    = {1'b0, duty_q} + STEP_9;
    assign diff_dn   = $signed({2'b00, duty_q}) - STEP_10;
    assign dwell_inc = dwell_q + 1'b1;

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        dwell_d = dwell_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        if (!enable) begin
            state_d = PH_IDLE;
            duty_d  = DUTY_MIN;
            dwell_d = '0;
        end else if (state_q == PH_IDLE) begin
            state_d = PH_UP;
            duty_d  = DUTY_MIN;
            dwell_d = '0;
        end else if (step_tick) begin
            tick_d = 1'b1;
            case (state_q)
                PH_UP: begin
                    if (sum_up >= {1'b0, DUTY_MAX}) begin
                        duty_d  = DUTY_MAX;
                        state_d = SKIP_DWELL ? PH_DOWN : PH_TOP;
                    end else begin
                        duty_d = sum_up[DUTY_W-1:0];
                    end
                end
                PH_TOP: begin
                    if (dwell_inc == DWELL_LAST) begin
                        dwell_d = '0;
                        state_d = PH_DOWN;
                    end else begin
                        dwell_d = dwell_inc;
                    end
                end
                PH_DOWN: begin
                    if (diff_dn <= $signed({2'b00, DUTY_MIN})) begin
                        duty_d = DUTY_MIN;
                        if (SKIP_DWELL) begin
                            state_d = PH_UP;
                            done_d  = 1'b1;
                        end else begin
                            state_d = PH_BOT;
                        end
                    end else begin
                        duty_d = diff_dn[DUTY_W-1:0];
                    end
                end
                PH_BOT: begin
                    if (dwell_inc == DWELL_LAST) begin
                        dwell_d = '0;
                        state_d = PH_UP;
                        done_d  = 1'b1;
                    end else begin
                        dwell_d = dwell_inc;
                    end
                end
                default: begin
                    state_d = PH_IDLE;
                    duty_d  = DUTY_MIN;
                    dwell_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= PH_IDLE;
            duty_q  <= DUTY_MIN;
            dwell_q <= '0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            dwell_q <= dwell_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

    assign duty_cycle  = duty_q;
    assign tick        = tick_q;
    assign phase       = state_q;
    assign period_done = done_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl: defaults, STEP=100 saturation, and a
// PRESCALE=1 / DWELL=0 instance, each with its own enable and freeze.
module tb_pwm_fade_ctrl;
    import pwm_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       en_a, frz_a, tick_a, done_a;
    logic [7:0] duty_a;
    logic [2:0] phase_a;
    logic       en_b, frz_b, tick_b, done_b;
    logic [7:0] duty_b;
    logic [2:0] phase_b;
    logic       en_c, frz_c, tick_c, done_c;
    logic [7:0] duty_c;
    logic [2:0] phase_c;

    pwm_fade_ctrl u_def (
        .clk (clk), .reset (reset), .enable (en_a), .freeze (frz_a),
        .duty_cycle (duty_a), .tick (tick_a), .phase (phase_a), .period_done (done_a)
    );

    pwm_fade_ctrl #(.STEP(100)) u_s100 (
        .clk (clk), .reset (reset), .enable (en_b), .freeze (frz_b),
        .duty_cycle (duty_b), .tick (tick_b), .phase (phase_b), .period_done (done_b)
    );

    pwm_fade_ctrl #(.PRESCALE(1), .DWELL(0)) u_fast (
        .clk (clk), .reset (reset), .enable (en_c), .freeze (frz_c),
        .duty_cycle (duty_c), .tick (tick_c), .phase (phase_c), .period_done (done_c)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    logic [7:0] exp_b_duty [8] = '{8'd100, 8'd200, 8'd255, 8'd255, 8'd255, 8'd155, 8'd55, 8'd0};
    logic [2:0] exp_b_ph   [8] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4};

    int cyc;
    bit found;
    bit held;
    bit seen_dwell;

    initial begin
        reset = 1'b0;
        en_a = 0; frz_a = 0; en_b = 0; frz_b = 0; en_c = 0; frz_c = 0;
        repeat (3) @(negedge clk);
        check("rst_duty", duty_a, 0);
        check("rst_tick", tick_a, 0);
        check("rst_phase", phase_a, PH_IDLE);
        check("rst_done", done_a, 0);
        check("rst_phase_fast", phase_c, PH_IDLE);

        reset = 1'b1;
        @(negedge clk);
        check("idle_no_enable", phase_a, PH_IDLE);

        // First duty change lands PRESCALE cycles after the edge entering UP.
        en_a = 1'b1;
        @(negedge clk);
        check("enter_up_phase", phase_a, PH_UP);
        check("enter_up_duty", duty_a, 0);
        repeat (15) @(negedge clk);
        check("pre_tick_duty", duty_a, 0);
        check("pre_tick_tick", tick_a, 0);
        @(negedge clk);
        check("first_tick_duty", duty_a, 8);
        check("first_tick_tick", tick_a, 1);
        repeat (31 * 16) @(negedge clk);
        check("ramp_top_duty", duty_a, 255);
        check("ramp_top_phase", phase_a, PH_TOP);

        // Breath of 68 ticks: first pulse at 1088 cycles after entering UP.
        cyc = 0; found = 0;
        while (!found && cyc < 3000) begin
            @(negedge clk); cyc++;
            if (done_a) found = 1;
        end
        check("done1_seen", found, 1);
        check("done1_cycles", cyc, 576);
        check("done1_duty", duty_a, 0);
        check("done1_phase", phase_a, PH_UP);
        cyc = 0; found = 0;
        while (!found && cyc < 3000) begin
            @(negedge clk); cyc++;
            if (done_a) found = 1;
        end
        check("done2_seen", found, 1);
        check("done2_period", cyc, 1088);
        check("done2_duty", duty_a, 0);
        @(negedge clk);
        check("done_one_cycle", done_a, 0);

        // Freeze mid-UP at duty 64, five cycles into the prescale window.
        cyc = 0; found = 0;
        while (!found && cyc < 500) begin
            @(negedge clk); cyc++;
            if (duty_a == 8'd64 && tick_a) found = 1;
        end
        check("reach_64", found, 1);
        repeat (5) @(negedge clk);
        frz_a = 1'b1;
        held = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (duty_a !== 8'd64 || tick_a !== 1'b0) held = 0;
        end
        check("freeze_hold", held, 1);
        check("freeze_phase", phase_a, PH_UP);
        frz_a = 1'b0;
        cyc = 0; found = 0;
        while (!found && cyc < 100) begin
            @(negedge clk); cyc++;
            if (tick_a) found = 1;
        end
        check("resume_tick_seen", found, 1);
        check("resume_tick_delay", cyc, 11);
        check("resume_duty", duty_a, 72);

        // Drop enable in DOWN at 127, then restart from the floor.
        cyc = 0; found = 0;
        while (!found && cyc < 2000) begin
            @(negedge clk); cyc++;
            if (phase_a == PH_DOWN && duty_a == 8'd127) found = 1;
        end
        check("reach_down_127", found, 1);
        en_a = 1'b0;
        @(negedge clk);
        check("disable_phase", phase_a, PH_IDLE);
        check("disable_duty", duty_a, 0);
        check("disable_tick", tick_a, 0);
        check("disable_done", done_a, 0);
        en_a = 1'b1;
        @(negedge clk);
        check("reenable_phase", phase_a, PH_UP);
        repeat (15) @(negedge clk);
        check("reenable_pre_duty", duty_a, 0);
        @(negedge clk);
        check("reenable_duty", duty_a, 8);

        // STEP=100: saturating up, clamping down, dwell ticks in between.
        en_b = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc = 0; found = 0;
            while (!found && cyc < 40) begin
                @(negedge clk); cyc++;
                if (tick_b) found = 1;
            end
            check($sformatf("s100_tick%0d_seen", k), found, 1);
            check($sformatf("s100_tick%0d_duty", k), duty_b, exp_b_duty[k]);
            check($sformatf("s100_tick%0d_phase", k), phase_b, exp_b_ph[k]);
        end
        en_b = 1'b0;

        // PRESCALE=1, DWELL=0: turn-around on consecutive ticks, no dwell states.
        en_c = 1'b1;
        cyc = 0; found = 0;
        while (!found && cyc < 100) begin
            @(negedge clk); cyc++;
            if (duty_c == 8'd248) found = 1;
        end
        check("fast_reach_248", found, 1);
        check("fast_248_phase", phase_c, PH_UP);
        @(negedge clk);
        check("fast_255_duty", duty_c, 255);
        check("fast_255_phase", phase_c, PH_DOWN);
        @(negedge clk);
        check("fast_247_duty", duty_c, 247);
        check("fast_247_phase", phase_c, PH_DOWN);
        cyc = 0; found = 0; seen_dwell = 0;
        while (!found && cyc < 200) begin
            @(negedge clk); cyc++;
            if (phase_c == PH_TOP || phase_c == PH_BOT) seen_dwell = 1;
            if (done_c) found = 1;
        end
        check("fast_done_seen", found, 1);
        check("fast_done_cycles", cyc, 31);
        check("fast_done_duty", duty_c, 0);
        check("fast_done_phase", phase_c, PH_UP);
        check("fast_no_dwell", seen_dwell, 0);
        en_c = 1'b0;

        // Asynchronous reset mid-ramp acts without waiting for an edge.
        repeat (100) @(negedge clk);
        check("pre_areset_nonzero", (duty_a != 8'd0), 1);
        #2 reset = 1'b0;
        #1;
        check("areset_duty", duty_a, 0);
        check("areset_phase", phase_a, PH_IDLE);
        check("areset_tick", tick_a, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_areset_phase", phase_a, PH_UP);
        check("post_areset_duty", duty_a, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
